// File: rtl/data_mem_responder.sv
// Word-addressed data RAM behind a valid/ready request channel.
// Serves scalar and BURST_LEN-beat reads/writes with configurable read latency.
module data_mem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int BURST_LEN    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_burst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_last,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CW = 4;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        WR_BURST,
        WR_ACK
    } state_t;

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state;
    logic [AW-1:0] base_q;
    logic [BW-1:0] beat_q;
    logic [CW-1:0] wait_q;
    logic          burst_q;
    logic          err_q;

    logic [29:0]   req_idx;
    logic [30:0]   req_last_idx;
    logic          req_err;
    logic          hs;

    // One extra index bit catches 30-bit overflow as out of range.
    assign req_idx      = req_addr[31:2];
    assign req_last_idx = {1'b0, req_idx} + (req_burst ? 31'(BURST_LEN - 1) : 31'd0);
    assign req_err      = (req_addr[1:0] != 2'b00) || (req_last_idx >= 31'(DEPTH_WORDS));
    assign req_ready    = !reset && (state == IDLE || state == WR_BURST);
    assign hs           = req_valid && req_ready;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_idx[AW-1:0];
        if (hs && state == IDLE && req_we && !req_err) begin
            mem_we = 1'b1;
        end else if (hs && state == WR_BURST && !err_q) begin
            mem_we    = 1'b1;
            mem_waddr = base_q + AW'(beat_q);
        end
    end

    // NOTE: the array has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= req_wdata;
        end
    end

    // Selects the read beat (if any) registered onto rsp_* at this edge.
    logic          rd_fire;
    logic [AW-1:0] rd_base;
    logic [BW-1:0] rd_k;
    logic          rd_err;
    logic          rd_burst;
    logic [AW-1:0] rd_addr;
    logic          rd_last;

    always_comb begin
        rd_fire  = 1'b0;
        rd_base  = base_q;
        rd_k     = beat_q;
        rd_err   = err_q;
        rd_burst = burst_q;
        unique case (state)
            IDLE: begin
                if (hs && !req_we && READ_LATENCY == 1) begin
                    rd_fire  = 1'b1;
                    rd_base  = req_idx[AW-1:0];
                    rd_k     = '0;
                    rd_err   = req_err;
                    rd_burst = req_burst;
                end
            end
            RD_WAIT: begin
                if (wait_q == CW'(1)) begin
                    rd_fire = 1'b1;
                    rd_k    = '0;
                end
            end
            RD_BEAT: begin
                if (!rsp_last) begin
                    rd_fire = 1'b1;
                    rd_k    = beat_q + BW'(1);
                end
            end
            default: ;
        endcase
    end

    assign rd_addr = rd_base + AW'(rd_k);
    assign rd_last = rd_err || !rd_burst || (rd_k == LAST_BEAT);

    // NOTE: sequential state uses non-blocking assignments only; later ones in the block win.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            base_q    <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            burst_q   <= 1'b0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (hs) begin
                        base_q  <= req_idx[AW-1:0];
                        burst_q <= req_burst;
                        err_q   <= req_err;
                        beat_q  <= '0;
                        if (req_we) begin
                            if (req_burst) begin
                                beat_q <= BW'(1);
                                state  <= WR_BURST;
                            end else begin
                                state     <= WR_ACK;
                                rsp_valid <= 1'b1;
                                rsp_last  <= 1'b1;
                                rsp_err   <= req_err;
                            end
                        end else if (READ_LATENCY == 1) begin
                            state <= RD_BEAT;
                        end else begin
                            wait_q <= CW'(READ_LATENCY - 1);
                            state  <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    wait_q <= wait_q - CW'(1);
                    if (wait_q == CW'(1)) begin
                        state <= RD_BEAT;
                    end
                end
                RD_BEAT: begin
                    if (rsp_last) begin
                        state <= IDLE;
                    end
                end
                WR_BURST: begin
                    if (hs) begin
                        if (beat_q == LAST_BEAT) begin
                            state     <= WR_ACK;
                            rsp_valid <= 1'b1;
                            rsp_last  <= 1'b1;
                            rsp_err   <= err_q;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                WR_ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (rd_fire) begin
                beat_q    <= rd_k;
                rsp_valid <= 1'b1;
                rsp_last  <= rd_last;
                rsp_err   <= rd_err;
                rsp_rdata <= rd_err ? 32'h0 : mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (read latency 2, 3, 1), table-driven
// requests with a timed response scoreboard, plus reset and back-to-back sequences.
module tb_data_mem_responder;

    localparam int NU = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [NU];
    logic        vld   [NU];
    logic        we    [NU];
    logic        bst   [NU];
    logic [31:0] addr  [NU];
    logic [31:0] wdata [NU];
    logic        rdy   [NU];
    logic        rv    [NU];
    logic [31:0] rd    [NU];
    logic        rl    [NU];
    logic        re    [NU];

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .BURST_LEN(4)) u_lat2 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we[0]),
        .req_burst(bst[0]), .req_addr(addr[0]), .req_wdata(wdata[0]), .rsp_valid(rv[0]),
        .rsp_rdata(rd[0]), .rsp_last(rl[0]), .rsp_err(re[0]));

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(3), .BURST_LEN(4)) u_lat3 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we[1]),
        .req_burst(bst[1]), .req_addr(addr[1]), .req_wdata(wdata[1]), .rsp_valid(rv[1]),
        .rsp_rdata(rd[1]), .rsp_last(rl[1]), .rsp_err(re[1]));

    data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .BURST_LEN(4)) u_lat1 (
        .clk(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we[2]),
        .req_burst(bst[2]), .req_addr(addr[2]), .req_wdata(wdata[2]), .rsp_valid(rv[2]),
        .rsp_rdata(rd[2]), .rsp_last(rl[2]), .rsp_err(re[2]));

    typedef struct {
        logic             we;
        logic             burst;
        logic [31:0]      addr;
        logic [3:0][31:0] wdata;
        int               gap;
        logic             err;
        logic [3:0][31:0] rdata;
    } vec_t;

    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] rdata;
        logic        last;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int u);
        case (u)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic vec_t mk(input logic w, input logic b, input logic [31:0] a,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input int gap, input logic err,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] r3);
        vec_t v;
        v.we = w; v.burst = b; v.addr = a; v.gap = gap; v.err = err;
        v.wdata[0] = w0; v.wdata[1] = w1; v.wdata[2] = w2; v.wdata[3] = w3;
        v.rdata[0] = r0; v.rdata[1] = r1; v.rdata[2] = r2; v.rdata[3] = r3;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every beat must match the head of the scoreboard, on time.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_err++;
            $display("FAIL rsp_missing u%0d: got no beat expected one at cycle %0d", e.u, e.cyc);
        end
        for (int u = 0; u < NU; u++) begin
            if (rv[u] === 1'b1) begin
                if (sb.size() == 0 || sb[0].u != u) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL rsp_unexpected u%0d: got beat 0x%0h expected none (cycle %0d)",
                             u, rd[u], cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("rsp_cycle_u%0d", u), 64'(cyc), 64'(e.cyc));
                    check($sformatf("rsp_beat_u%0d", u), {30'b0, rd[u], rl[u], re[u]},
                          {30'b0, e.rdata, e.last, e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int u, input int n);
        vld[u] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input int u, output int t);
        int n = 0;
        while (rdy[u] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("req_ready_u%0d", u), {63'b0, rdy[u]}, 64'd1);
        t = cyc + 1;
    endtask

    // Drives one request (all beats for a burst write); t0 is the first handshake edge.
    task automatic do_req(input int u, input vec_t v, output int t0);
        int t;
        int beats;
        int l;
        beats = v.burst ? 4 : 1;
        l = lat_of(u);
        we[u] = v.we; bst[u] = v.burst; addr[u] = v.addr; wdata[u] = v.wdata[0]; vld[u] = 1'b1;
        wait_ready(u, t);
        t0 = t;
        if (!v.we) begin
            if (v.err)
                sb.push_back('{u: u, cyc: t + l - 1, rdata: 32'h0, last: 1'b1, err: 1'b1});
            else
                for (int k = 0; k < beats; k++)
                    sb.push_back('{u: u, cyc: t + l - 1 + k, rdata: v.rdata[k],
                                   last: (k == beats - 1), err: 1'b0});
        end else if (!v.burst) begin
            sb.push_back('{u: u, cyc: t, rdata: 32'h0, last: 1'b1, err: v.err});
        end
        step();
        if (v.we && v.burst) begin
            for (int k = 1; k < 4; k++) begin
                if (k == 2 && v.gap > 0) begin
                    vld[u] = 1'b0;
                    repeat (v.gap) @(negedge clk);
                end
                we[u] = 1'b0; bst[u] = 1'b0; addr[u] = 32'hFFFF_FFFF;
                wdata[u] = v.wdata[k]; vld[u] = 1'b1;
                wait_ready(u, t);
                if (k == 3)
                    sb.push_back('{u: u, cyc: t, rdata: 32'h0, last: 1'b1, err: v.err});
                step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[20];
        logic [31:0] b2b_vals[3];
        int          t;
        int          ts[3];
        int          n;

        tbl[0]  = mk(1, 0, 32'h10,  32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h10,  0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[2]  = mk(1, 1, 32'h40,  32'h11, 32'h22, 32'h33, 32'h44, 2, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 32'h40,  0, 0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
        tbl[4]  = mk(0, 0, 32'h13,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 32'h10,  0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[6]  = mk(1, 0, 32'hFF8, 32'h5A5A0001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 0, 32'hFFC, 32'h5A5A0002, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 32'hFF8, 32'hEE01, 32'hEE02, 32'hEE03, 32'hEE04, 0, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 32'hFF8, 0, 0, 0, 0, 0, 0, 32'h5A5A0001, 0, 0, 0);
        tbl[10] = mk(0, 0, 32'hFFC, 0, 0, 0, 0, 0, 0, 32'h5A5A0002, 0, 0, 0);
        tbl[11] = mk(0, 1, 32'hFF4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 32'h1000, 32'h12345678, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[13] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 32'h12,  32'h0BAD0BAD, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 32'h10,  0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        tbl[16] = mk(1, 1, 32'h41,  32'h99, 32'h98, 32'h97, 32'h96, 0, 1, 0, 0, 0, 0);
        tbl[17] = mk(0, 1, 32'h40,  0, 0, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
        tbl[18] = mk(1, 1, 32'hFF0, 32'h61, 32'h62, 32'h63, 32'h64, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 32'hFF0, 0, 0, 0, 0, 0, 0, 32'h61, 32'h62, 32'h63, 32'h64);

        b2b_vals[0] = 32'hA1A1A1A1;
        b2b_vals[1] = 32'hB2B2B2B2;
        b2b_vals[2] = 32'hC3C3C3C3;

        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1; vld[u] = 1'b0; we[u] = 1'b0; bst[u] = 1'b0;
            addr[u] = 32'h0; wdata[u] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++)
            check($sformatf("reset_outputs_u%0d", u),
                  {28'b0, rdy[u], rv[u], rl[u], re[u], rd[u]}, 64'd0);
        for (int u = 0; u < NU; u++) rst[u] = 1'b0;
        #1;
        for (int u = 0; u < NU; u++)
            check($sformatf("ready_after_reset_u%0d", u), {63'b0, rdy[u]}, 64'd1);
        @(negedge clk);

        // Table-driven requests on the latency-2 instance.
        for (int i = 0; i < 20; i++) begin
            do_req(0, tbl[i], t);
            idle(0, 8);
        end

        // Latency 3: reset lands while the second burst beat is on the bus.
        do_req(1, mk(1, 1, 32'h80, 32'h1, 32'h2, 32'h3, 32'h4, 0, 0, 0, 0, 0, 0), t);
        idle(1, 3);
        do_req(1, mk(0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 32'h1, 32'h2, 32'h3, 32'h4), t);
        vld[1] = 1'b0;
        n = 0;
        while (cyc < t + 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        sb.delete();
        rst[1] = 1'b1;
        @(negedge clk);
        check("reset_held_quiet", {62'b0, rdy[1], rv[1]}, 64'd0);
        rst[1] = 1'b0;
        #1;
        check("reset_release_ready", {63'b0, rdy[1]}, 64'd1);
        check("reset_release_no_beat", {63'b0, rv[1]}, 64'd0);
        idle(1, 8);
        do_req(1, mk(0, 0, 32'h8C, 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0), t);
        idle(1, 8);

        // Latency 1: back-to-back scalar reads with req_valid held high.
        for (int i = 0; i < 3; i++) begin
            do_req(2, mk(1, 0, 32'h100 + 32'(4 * i), b2b_vals[i], 0, 0, 0, 0, 0, 0, 0, 0, 0), t);
            idle(2, 2);
        end
        for (int i = 0; i < 3; i++)
            do_req(2, mk(0, 0, 32'h100 + 32'(4 * i), 0, 0, 0, 0, 0, 0, b2b_vals[i], 0, 0, 0), ts[i]);
        idle(2, 4);
        check("b2b_spacing_1", 64'(ts[1] - ts[0]), 64'd2);
        check("b2b_spacing_2", 64'(ts[2] - ts[1]), 64'd2);

        idle(0, 5);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store path: owns a word-addressed data RAM and serves scalar and 4-beat vector (burst) reads and writes over a 32-bit valid/ready request channel and a 32-bit response channel. It sits between the load/store unit and the data memory array. It turns one accepted burst request into BURST_LEN consecutive word accesses at base, base+4, base+8 and base+12. Read latency is configurable to model slow memory.

## Interface
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two.
- READ_LATENCY, 1: cycles from request acceptance to first read beat; legal range 1..8.
- BURST_LEN, 4: beats per vector burst (4 × 32 = 128 bits).

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  requester presents a request or a write beat.
- req_ready  out  1  responder can accept; handshake = req_valid & req_ready at a rising edge.
- req_we  in  1  1 = write, 0 = read; sampled on the first beat only.
- req_burst  in  1  1 = vector burst of BURST_LEN beats; sampled on the first beat only.
- req_addr  in  32  byte address; sampled on the first beat only.
- req_wdata  in  32  write data for the current beat.
- rsp_valid  out  1  response beat valid, single-cycle per beat; no back-pressure.
- rsp_rdata  out  32  read data; 0 on write acks and errors.
- rsp_last  out  1  final beat of a response.
- rsp_err  out  1  request rejected because the address is misaligned or out of range.

## Operation
- States: IDLE, RD_WAIT, RD_BEAT, WR_BURST, WR_ACK.
- Address rule:
  - word index = req_addr[31:2].
  - Error if req_addr[1:0] != 0.
  - Error if the last touched index (base + BURST_LEN−1 for a burst, base for a scalar) ≥ DEPTH_WORDS.
  - Index arithmetic is 30-bit with no wrap. An overflow counts as an error.
- IDLE: req_ready = 1. On handshake:
  - Scalar write, no error: RAM[index] ← req_wdata at that edge. Go to WR_ACK.
  - Burst write: beat 0 is written at that edge (suppressed if error). Beat counter = 1. Go to WR_BURST.
  - Read, scalar or burst: latch base index, burst flag and error flag. Wait counter = READ_LATENCY−1. Go to RD_BEAT if the counter is 0, else to RD_WAIT.
- RD_WAIT: req_ready = 0. Decrement the counter each cycle. Go to RD_BEAT when it reaches 0.
- RD_BEAT: req_ready = 0. rsp_valid = 1 and rsp_rdata = RAM[base+k] for beat k.
  - Scalar: one beat, rsp_last = 1.
  - Burst: beats k = 0..BURST_LEN−1 in consecutive cycles, no gaps; rsp_last = 1 on k = BURST_LEN−1.
  - Error: one beat with rsp_err = 1, rsp_last = 1, rsp_rdata = 0.
  - After the last beat, go to IDLE.
- WR_BURST: req_ready = 1.
  - Each handshake writes req_wdata to base+k and increments k. req_we, req_burst and req_addr are ignored.
  - Cycles with req_valid low are gaps; the state holds.
  - After beat BURST_LEN−1 is written, go to WR_ACK.
  - Errored bursts still consume all beats but write nothing.
- WR_ACK: req_ready = 0. One cycle with rsp_valid = 1, rsp_last = 1, rsp_rdata = 0 and rsp_err = the latched flag. Then go to IDLE.
- Reset (any state, including mid-burst): go to IDLE, clear counters and flags, drop any pending response. The RAM is not cleared; its contents are undefined until written.

## Timing
- Reset values: req_ready = 0 while reset is high and 1 in the first cycle after. rsp_valid, rsp_rdata, rsp_last and rsp_err are 0.
- All rsp_* outputs are registered.
- req_ready is combinational from state, gated by reset.
- Read: handshake at edge T. First beat visible in the cycle after edge T+READ_LATENCY−1, i.e. READ_LATENCY cycles after acceptance. Burst beat k follows k cycles later.
- req_ready returns high in the cycle after the last read beat. A new request can be accepted at the first edge after that beat.
- Write: the RAM update happens at the handshake edge. The ack appears the cycle after the final beat's handshake.
- Minimum burst write = BURST_LEN + 1 cycles, ack included.
- Read-after-write to the same address returns the new data, because the write commits before the read is accepted.
- Single port: at most one RAM access per cycle.

## Test plan
- READ_LATENCY=2. Scalar write 0xDEADBEEF to 0x10, then scalar read of 0x10 → ack the cycle after the write; read data 0xDEADBEEF with rsp_last=1 exactly 2 cycles after the read handshake.
- Burst write 0x11, 0x22, 0x33, 0x44 at 0x40, with a 2-cycle req_valid gap after beat 1 → one ack after beat 3. A following burst read of 0x40 returns 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, rsp_last on 0x44.
- Scalar read of 0x13 (misaligned) → one beat with rsp_err=1, rsp_rdata=0, rsp_last=1. Memory unchanged.
- DEPTH_WORDS=1024: burst write at 0xFF8 (it would cross the end of memory) → 4 beats consumed, ack with rsp_err=1. Reading words 0x3FE and 0x3FF returns their prior values.
- READ_LATENCY=3: assert reset during the second beat of a burst read → the next cycle has rsp_valid=0 and req_ready=1 after reset is released, with no further beats.
- READ_LATENCY=1: back-to-back scalar reads with req_valid held high → one accepted every 2 cycles; each response arrives 1 cycle after its acceptance.
